// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared FSM state type, default width and counter-width helper for the shift stages
package shift_reg_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEFAULT_WIDTH = 4;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/bit_counter.sv
// bit_counter: clearable up-counter flagging the last bit (count == N-1) of an N-bit frame
module bit_counter
  import shift_reg_pkg::*;
#(
  parameter int N  = DEFAULT_WIDTH,
  parameter int CW = cnt_width(DEFAULT_WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  // clear wins over increment so a reload restarts at bit 0
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign tc = cnt == CW'(N - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out stage; define PISO_PARITY_EN to append an even-parity bit
module piso_serializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = cnt_width(WIDTH);
  state_t          state_q, state_d;
  logic [WIDTH-1:0] ord;
  logic [N-1:0]    frm, sh;
  logic [CW-1:0]   cnt;
  logic            tc, acc, adv, fin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ord
    assign ord[i] = MSB_FIRST ? d[WIDTH-1-i] : d[i];
  end
`ifdef PISO_PARITY_EN
  assign frm = {^d, ord};
`else
  assign frm = ord;
`endif
  assign busy = state_q == SHIFT;
  bit_counter #(.N(N), .CW(CW)) u_cnt (
    .clk(clk), .reset_n(reset_n), .clr(acc || fin), .inc(adv), .cnt(cnt), .tc(tc)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  // ready depends only on state, so a word may be taken on the last-bit edge for gap-free reload
  always_comb begin
    fin        = state_q == SHIFT && tc;
    adv        = state_q == SHIFT && !tc;
    load_ready = state_q == IDLE || fin;
    acc        = load_valid && load_ready;
    state_d    = acc ? SHIFT : fin ? IDLE : state_q;
  end
  // frame is held in transmit order; bit 0 of the shift register is always the next bit out
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sh         <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
    end else if (acc) begin
      sh         <= frm >> 1;
      sout       <= frm[0];
      sout_valid <= 1'b1;
      sout_last  <= 1'b0;
    end else if (adv) begin
      sh         <= sh >> 1;
      sout       <= sh[0];
      sout_last  <= cnt == CW'(N - 2);
    end else if (fin) begin
      sh         <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized and directed checks of piso_serializer against a frame-level model
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int N = PAR ? 5 : 4;
  logic clk = 1'b0, reset_n = 1'b0, load_valid = 1'b0;
  logic [3:0] d = 4'h0;
  logic load_ready, sout, sout_valid, sout_last, busy;
  int total = 0, bad = 0;
  int pos = -1;
  logic [4:0] fr = '0;
  logic seen[$];
  int n_last, n_busy, n_rb, n_val;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .d(d), .load_valid(load_valid), .load_ready(load_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return pos < 0 || pos == N - 1;
  endfunction

  function automatic int packed_seen();
    int v = 0;
    foreach (seen[i]) v = (v << 1) | int'(seen[i]);
    return v;
  endfunction

  // frame-level model: which bit of which captured word is on the line this cycle
  always @(posedge clk or negedge reset_n)
    if (!reset_n) pos = -1;
    else if (m_ready() && load_valid) begin
      for (int k = 0; k < 4; k++) fr[k] = d[3-k];
      fr[4] = ^d;
      pos = 0;
    end else if (pos >= 0) pos = (pos == N - 1) ? -1 : pos + 1;

  // single compare process, mid-cycle
  always @(negedge clk)
    if (reset_n) begin
      chk("sout", int'(sout), pos >= 0 ? int'(fr[pos]) : 0);
      chk("sout_valid", int'(sout_valid), int'(pos >= 0));
      chk("sout_last", int'(sout_last), int'(pos == N - 1));
      chk("busy", int'(busy), int'(pos >= 0));
      chk("load_ready", int'(load_ready), int'(m_ready()));
      if (sout_valid) begin seen.push_back(sout); n_val++; end
      if (sout_last) n_last++;
      if (busy) n_busy++;
      if (busy && load_ready) n_rb++;
    end

  task automatic clr_logs();
    seen.delete();
    n_last = 0; n_busy = 0; n_rb = 0; n_val = 0;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [3:0] w);
    bit acc = 1'b0;
    d = w;
    load_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = m_ready();
      @(posedge clk);
      @(negedge clk);
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  initial begin
    clr_logs();
    #1300;
    chk("rst_sout", int'(sout), 0);
    chk("rst_valid", int'(sout_valid), 0);
    chk("rst_last", int'(sout_last), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_ready", int'(load_ready), 1);
    repeat (5) @(negedge clk);
    chk("idle_valid_cnt", n_val, 0);

    clr_logs();
    send(4'b1011);
    load_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("single_seq", packed_seen(), PAR ? 'b10111 : 'b1011);
    chk("single_len", seen.size(), N);
    chk("single_last", n_last, 1);
    chk("single_busy", n_busy, N);

    clr_logs();
    send(4'hA);
    send(4'h5);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_seq", packed_seen(), PAR ? 'b1010001010 : 'hA5);
    chk("b2b_valid", n_val, 2 * N);
    chk("b2b_busy", n_busy, 2 * N);
    chk("b2b_ready_busy", n_rb, 2);

    clr_logs();
    send(4'h6);
    send(4'hF);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignore_seq", packed_seen(), PAR ? 'b0110011110 : 'h6F);
    chk("ignore_len", seen.size(), 2 * N);

    send(4'hC);
    load_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", int'(sout_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sout", int'(sout), 0);
    chk("mid_rst_valid", int'(sout_valid), 0);
    chk("mid_rst_last", int'(sout_last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clr_logs();
    repeat (3) @(negedge clk);
    chk("post_rst_quiet", n_val, 0);
    send(4'h3);
    load_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("post_rst_seq", packed_seen(), PAR ? 'b00110 : 'b0011);
    chk("post_rst_len", seen.size(), N);

`ifdef PISO_PARITY_EN
    clr_logs();
    send(4'b0111);
    load_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("par_seq_0111", packed_seen(), 'b01111);
    chk("par_last", n_last, 1);
    clr_logs();
    send(4'b0110);
    load_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("par_seq_0110", packed_seen(), 'b01100);
`endif

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      load_valid = ($urandom_range(0, 3) != 0);
      d = 4'($urandom);
    end
    @(negedge clk);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
